// File: rtl/reservation_station_multi_if.sv
// ---------------------------------------------------------------------------
// reservation_station_multi_if
// Bundles the issue-side, CDB, downstream-backpressure and dispatch-side
// signals of the multi-entry reservation station.
//   master : the environment (issue buffer, CDB, output latch) driving inputs
//   slave  : the reservation station itself
// Signals:
//   in_hasInput/in_device/in_algorithm/in_valueA/in_valueB : issued micro-op,
//       operands packed as {ready, tag, value}
//   cdb_buzy/cdb_device/cdb_value : common data bus broadcast
//   nxt_buzy  : downstream output latch cannot accept
//   out_full/out_accept/out_valid/out_algorithm/out_valueA/out_valueB/
//   out_count : station status and the presented micro-op
// ---------------------------------------------------------------------------
interface reservation_station_multi_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3,
    parameter int ALGO_W = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OP_W  = DATA_W + TAG_W + 1;

    logic              in_hasInput;
    logic [TAG_W-1:0]  in_device;
    logic [ALGO_W-1:0] in_algorithm;
    logic [OP_W-1:0]   in_valueA;
    logic [OP_W-1:0]   in_valueB;
    logic              cdb_buzy;
    logic [TAG_W-1:0]  cdb_device;
    logic [DATA_W-1:0] cdb_value;
    logic              nxt_buzy;
    logic              out_full;
    logic              out_accept;
    logic              out_valid;
    logic [ALGO_W-1:0] out_algorithm;
    logic [DATA_W-1:0] out_valueA;
    logic [DATA_W-1:0] out_valueB;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_hasInput, in_device, in_algorithm, in_valueA, in_valueB,
        output cdb_buzy, cdb_device, cdb_value, nxt_buzy,
        input  out_full, out_accept, out_valid, out_algorithm,
        input  out_valueA, out_valueB, out_count
    );

    modport slave (
        input  in_hasInput, in_device, in_algorithm, in_valueA, in_valueB,
        input  cdb_buzy, cdb_device, cdb_value, nxt_buzy,
        output out_full, out_accept, out_valid, out_algorithm,
        output out_valueA, out_valueB, out_count
    );
endinterface

// File: rtl/reservation_station_multi.sv
// ---------------------------------------------------------------------------
// reservation_station_multi
// Multi-entry reservation station in front of one execution unit. Entries are
// kept in a compacting queue (slot 0 = oldest). Pending operands capture their
// value from the CDB; the oldest entry with both operands ready is presented
// on a valid/ready handshake (ready = !nxt_buzy) and removed when taken.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset, discards every entry
//   bus  : reservation_station_multi_if.slave (issue, CDB, dispatch signals)
// Configuration:
//   RS_INSERT_FWD_EN : when defined, a pending operand whose tag is on the CDB
//                      in the accept cycle is stored already resolved.
// ---------------------------------------------------------------------------
module reservation_station_multi #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 3,
    parameter int ALGO_W    = 2,
    parameter int DEVICE_ID = 1
) (
    input logic                        clk,
    input logic                        rst,
    reservation_station_multi_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              busy;
        logic [ALGO_W-1:0] alg;
        logic              a_rdy;
        logic [TAG_W-1:0]  a_tag;
        logic [DATA_W-1:0] a_val;
        logic              b_rdy;
        logic [TAG_W-1:0]  b_tag;
        logic [DATA_W-1:0] b_val;
    } entry_t;

    entry_t            slot_q [DEPTH];
    entry_t            slot_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  at_or_above;
    logic              sel_found;
    entry_t            sel_entry;
    logic              full, accept, dispatch;
    logic [CNT_W-1:0]  ins_pos;
    entry_t            new_entry;

    // Oldest-ready selection. at_or_above marks the selected slot and every
    // younger one: exactly the slots that move when the selection dispatches.
    always_comb begin
        sel_found   = 1'b0;
        sel_entry   = '0;
        at_or_above = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && slot_q[i].busy && slot_q[i].a_rdy && slot_q[i].b_rdy) begin
                sel_found = 1'b1;
                sel_entry = slot_q[i];
            end
            at_or_above[i] = sel_found;
        end
    end

    // Fullness is judged on the registered count, so a slot freed by this
    // cycle's dispatch cannot be refilled until the next cycle.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        accept   = bus.in_hasInput && (bus.in_device == TAG_W'(DEVICE_ID)) && !full;
        dispatch = sel_found && !bus.nxt_buzy;
        ins_pos  = count_q - CNT_W'(dispatch);
    end

    // Incoming micro-op as it will be written into the queue.
    always_comb begin
        new_entry       = '0;
        new_entry.busy  = 1'b1;
        new_entry.alg   = bus.in_algorithm;
        new_entry.a_rdy = bus.in_valueA[DATA_W+TAG_W];
        new_entry.a_tag = bus.in_valueA[DATA_W+TAG_W-1:DATA_W];
        new_entry.a_val = bus.in_valueA[DATA_W-1:0];
        new_entry.b_rdy = bus.in_valueB[DATA_W+TAG_W];
        new_entry.b_tag = bus.in_valueB[DATA_W+TAG_W-1:DATA_W];
        new_entry.b_val = bus.in_valueB[DATA_W-1:0];
`ifdef RS_INSERT_FWD_EN
        // Close the race where the producer broadcasts in the issue cycle.
        if (bus.cdb_buzy && !new_entry.a_rdy && new_entry.a_tag == bus.cdb_device) begin
            new_entry.a_rdy = 1'b1;
            new_entry.a_tag = '0;
            new_entry.a_val = bus.cdb_value;
        end
        if (bus.cdb_buzy && !new_entry.b_rdy && new_entry.b_tag == bus.cdb_device) begin
            new_entry.b_rdy = 1'b1;
            new_entry.b_tag = '0;
            new_entry.b_val = bus.cdb_value;
        end
`endif
    end

    // Next queue contents: compact over the dispatched slot, then snoop the
    // CDB on the entries at their new positions, then append the new entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (dispatch) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (at_or_above[i]) begin
                    slot_d[i] = slot_q[i+1];
                end
            end
            if (at_or_above[DEPTH-1]) begin
                slot_d[DEPTH-1] = '0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_d[i].busy && bus.cdb_buzy) begin
                if (!slot_d[i].a_rdy && slot_d[i].a_tag == bus.cdb_device) begin
                    slot_d[i].a_rdy = 1'b1;
                    slot_d[i].a_tag = '0;
                    slot_d[i].a_val = bus.cdb_value;
                end
                if (!slot_d[i].b_rdy && slot_d[i].b_tag == bus.cdb_device) begin
                    slot_d[i].b_rdy = 1'b1;
                    slot_d[i].b_tag = '0;
                    slot_d[i].b_val = bus.cdb_value;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && ins_pos == CNT_W'(i)) begin
                slot_d[i] = new_entry;
            end
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(dispatch);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_d;
        end
    end

    assign bus.out_full      = full;
    assign bus.out_accept    = accept;
    assign bus.out_valid     = sel_found;
    assign bus.out_algorithm = sel_entry.alg;
    assign bus.out_valueA    = sel_entry.a_val;
    assign bus.out_valueB    = sel_entry.b_val;
    assign bus.out_count     = count_q;
endmodule

// File: tb/tb_reservation_station_multi.sv
// ---------------------------------------------------------------------------
// tb_reservation_station_multi
// Self-checking bench for reservation_station_multi. A queue-based model of
// the station predicts every output each cycle; directed scenarios add
// hand-computed literal expectations, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_reservation_station_multi;
    localparam int DEPTH     = 4;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 3;
    localparam int ALGO_W    = 2;
    localparam int DEVICE_ID = 1;
    localparam int OP_W      = DATA_W + TAG_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    reservation_station_multi_if #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .ALGO_W(ALGO_W)
    ) bus ();

    reservation_station_multi #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .ALGO_W(ALGO_W),
        .DEVICE_ID(DEVICE_ID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [ALGO_W-1:0] alg;
        logic              a_rdy;
        logic [TAG_W-1:0]  a_tag;
        logic [DATA_W-1:0] a_val;
        logic              b_rdy;
        logic [TAG_W-1:0]  b_tag;
        logic [DATA_W-1:0] b_val;
    } mentry_t;

    mentry_t mq[$];

    int checks = 0;
    int errors = 0;

    logic              exp_valid, exp_full, exp_accept;
    logic [ALGO_W-1:0] exp_alg;
    logic [DATA_W-1:0] exp_va, exp_vb;
    int                exp_count;
    int                exp_sel;

    function automatic logic [OP_W-1:0] opnd(input logic rdy, input logic [TAG_W-1:0] tag,
                                            input logic [DATA_W-1:0] val);
        return {rdy, tag, val};
    endfunction

    // A pending operand whose tag is broadcast becomes ready with the value.
    function automatic mentry_t snoop(input mentry_t e, input logic [TAG_W-1:0] dev,
                                      input logic [DATA_W-1:0] val);
        mentry_t r = e;
        if (!r.a_rdy && r.a_tag == dev) begin
            r.a_rdy = 1'b1; r.a_tag = '0; r.a_val = val;
        end
        if (!r.b_rdy && r.b_tag == dev) begin
            r.b_rdy = 1'b1; r.b_tag = '0; r.b_val = val;
        end
        return r;
    endfunction

    // Expected outputs from the model queue and the current inputs.
    function automatic void modelEval();
        exp_sel   = -1;
        exp_valid = 1'b0;
        exp_alg   = '0;
        exp_va    = '0;
        exp_vb    = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (exp_sel < 0 && mq[i].a_rdy && mq[i].b_rdy) exp_sel = i;
        end
        if (exp_sel >= 0) begin
            exp_valid = 1'b1;
            exp_alg   = mq[exp_sel].alg;
            exp_va    = mq[exp_sel].a_val;
            exp_vb    = mq[exp_sel].b_val;
        end
        exp_count  = mq.size();
        exp_full   = (exp_count == DEPTH);
        exp_accept = bus.in_hasInput && (bus.in_device == TAG_W'(DEVICE_ID)) && !exp_full;
    endfunction

    // Clock edge in the model: remove the taken entry, snoop, then append.
    task automatic modelUpdate();
        mentry_t e;
        modelEval();
        if (exp_valid && !bus.nxt_buzy) mq.delete(exp_sel);
        if (bus.cdb_buzy) begin
            for (int i = 0; i < mq.size(); i++) mq[i] = snoop(mq[i], bus.cdb_device, bus.cdb_value);
        end
        if (exp_accept) begin
            e.alg   = bus.in_algorithm;
            e.a_rdy = bus.in_valueA[OP_W-1];
            e.a_tag = bus.in_valueA[OP_W-2:DATA_W];
            e.a_val = bus.in_valueA[DATA_W-1:0];
            e.b_rdy = bus.in_valueB[OP_W-1];
            e.b_tag = bus.in_valueB[OP_W-2:DATA_W];
            e.b_val = bus.in_valueB[DATA_W-1:0];
`ifdef RS_INSERT_FWD_EN
            if (bus.cdb_buzy) e = snoop(e, bus.cdb_device, bus.cdb_value);
`endif
            mq.push_back(e);
        end
    endtask

    task automatic compareField(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        modelEval();
        compareField("out_full",      64'(bus.out_full),      64'(exp_full));
        compareField("out_accept",    64'(bus.out_accept),    64'(exp_accept));
        compareField("out_valid",     64'(bus.out_valid),     64'(exp_valid));
        compareField("out_algorithm", 64'(bus.out_algorithm), 64'(exp_alg));
        compareField("out_valueA",    64'(bus.out_valueA),    64'(exp_va));
        compareField("out_valueB",    64'(bus.out_valueB),    64'(exp_vb));
        compareField("out_count",     64'(bus.out_count),     64'(exp_count));
    endtask

    task automatic applyStimulus(input logic has, input logic [TAG_W-1:0] dev,
                                 input logic [ALGO_W-1:0] alg, input logic [OP_W-1:0] va,
                                 input logic [OP_W-1:0] vb, input logic cb,
                                 input logic [TAG_W-1:0] cdev, input logic [DATA_W-1:0] cval,
                                 input logic nb);
        bus.in_hasInput  = has;
        bus.in_device    = dev;
        bus.in_algorithm = alg;
        bus.in_valueA    = va;
        bus.in_valueB    = vb;
        bus.cdb_buzy     = cb;
        bus.cdb_device   = cdev;
        bus.cdb_value    = cval;
        bus.nxt_buzy     = nb;
        #2;
    endtask

    task automatic idle(input logic nb);
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, nb);
    endtask

    // Called just after a falling edge with inputs applied and settled.
    task automatic runCycle();
        checkOutput();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    initial begin
        idle(1'b0);
        repeat (2) @(negedge clk);
        compareField("reset_count", 64'(bus.out_count), 64'd0);
        compareField("reset_valid", 64'(bus.out_valid), 64'd0);
        compareField("reset_full",  64'(bus.out_full),  64'd0);
        rst = 1'b1;
        idle(1'b0);
        runCycle();

        // Single ready micro-op passes straight through.
        applyStimulus(1'b1, 3'd1, 2'd1, opnd(1'b1, 3'd0, 32'd5), opnd(1'b1, 3'd0, 32'd7), 1'b0, '0, '0, 1'b0);
        compareField("t1_accept", 64'(bus.out_accept), 64'd1);
        runCycle();
        idle(1'b0);
        compareField("t1_valid", 64'(bus.out_valid),     64'd1);
        compareField("t1_A",     64'(bus.out_valueA),    64'd5);
        compareField("t1_B",     64'(bus.out_valueB),    64'd7);
        compareField("t1_alg",   64'(bus.out_algorithm), 64'd1);
        runCycle();
        idle(1'b0);
        compareField("t1_count", 64'(bus.out_count), 64'd0);
        runCycle();

        // Fill with entries waiting on tag 3, then wake them all at once.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 3'd1, 2'd2, opnd(1'b0, 3'd3, 32'd0), opnd(1'b1, 3'd0, 32'(i + 1)), 1'b0, '0, '0, 1'b0);
            runCycle();
        end
        applyStimulus(1'b1, 3'd1, 2'd2, opnd(1'b1, 3'd0, 32'd1), opnd(1'b1, 3'd0, 32'd1), 1'b0, '0, '0, 1'b0);
        compareField("t2_full",   64'(bus.out_full),   64'd1);
        compareField("t2_valid",  64'(bus.out_valid),  64'd0);
        compareField("t2_accept", 64'(bus.out_accept), 64'd0);
        runCycle();
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 3'd3, 32'h10, 1'b0);
        runCycle();
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b0);
            compareField("t2_order_A", 64'(bus.out_valueA), 64'h10);
            compareField("t2_order_B", 64'(bus.out_valueB), 64'(i + 1));
            runCycle();
        end
        idle(1'b0);
        compareField("t2_drained", 64'(bus.out_count), 64'd0);
        runCycle();

        // Younger ready entry bypasses an older waiting one.
        applyStimulus(1'b1, 3'd1, 2'd0, opnd(1'b0, 3'd2, 32'd0), opnd(1'b1, 3'd0, 32'd1), 1'b0, '0, '0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 3'd1, 2'd3, opnd(1'b1, 3'd0, 32'd9), opnd(1'b1, 3'd0, 32'd2), 1'b0, '0, '0, 1'b0);
        runCycle();
        idle(1'b0);
        compareField("t3_valid", 64'(bus.out_valid), 64'd1);
        compareField("t3_A",     64'(bus.out_valueA), 64'd9);
        runCycle();
        idle(1'b0);
        compareField("t3_wait_valid", 64'(bus.out_valid), 64'd0);
        compareField("t3_wait_count", 64'(bus.out_count), 64'd1);
        runCycle();
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 3'd2, 32'h22, 1'b0);
        runCycle();
        idle(1'b0);
        compareField("t3_woken_A", 64'(bus.out_valueA), 64'h22);
        runCycle();

        // Full station: dispatch and issue in the same cycle.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 3'd1, 2'd1, opnd(1'b1, 3'd0, 32'(i + 20)), opnd(1'b1, 3'd0, 32'd0), 1'b0, '0, '0, 1'b1);
            runCycle();
        end
        applyStimulus(1'b1, 3'd1, 2'd2, opnd(1'b1, 3'd0, 32'd30), opnd(1'b1, 3'd0, 32'd31), 1'b0, '0, '0, 1'b0);
        compareField("t4_full",   64'(bus.out_full),   64'd1);
        compareField("t4_accept", 64'(bus.out_accept), 64'd0);
        runCycle();
        applyStimulus(1'b1, 3'd1, 2'd2, opnd(1'b1, 3'd0, 32'd30), opnd(1'b1, 3'd0, 32'd31), 1'b0, '0, '0, 1'b1);
        compareField("t4_count3", 64'(bus.out_count),  64'd3);
        compareField("t4_accept2", 64'(bus.out_accept), 64'd1);
        runCycle();
        idle(1'b1);
        compareField("t4_count4", 64'(bus.out_count), 64'd4);
        runCycle();
        repeat (DEPTH) begin
            idle(1'b0);
            runCycle();
        end

        // Backpressure holds the presented entry.
        applyStimulus(1'b1, 3'd1, 2'd3, opnd(1'b1, 3'd0, 32'h77), opnd(1'b1, 3'd0, 32'h78), 1'b0, '0, '0, 1'b1);
        runCycle();
        repeat (3) begin
            idle(1'b1);
            compareField("t5_hold_valid", 64'(bus.out_valid),  64'd1);
            compareField("t5_hold_A",     64'(bus.out_valueA), 64'h77);
            runCycle();
        end
        idle(1'b0);
        runCycle();
        idle(1'b0);
        compareField("t5_removed", 64'(bus.out_count), 64'd0);
        runCycle();

        // Issue while the awaited tag is on the CDB.
        applyStimulus(1'b1, 3'd1, 2'd2, opnd(1'b0, 3'd2, 32'd0), opnd(1'b1, 3'd0, 32'd3), 1'b1, 3'd2, 32'h55, 1'b0);
        runCycle();
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 3'd2, 32'h66, 1'b0);
`ifdef RS_INSERT_FWD_EN
        compareField("t6_fwd_valid", 64'(bus.out_valid),  64'd1);
        compareField("t6_fwd_A",     64'(bus.out_valueA), 64'h55);
`else
        compareField("t6_pend_valid", 64'(bus.out_valid), 64'd0);
`endif
        runCycle();
        idle(1'b0);
`ifdef RS_INSERT_FWD_EN
        compareField("t6_fwd_count", 64'(bus.out_count), 64'd0);
`else
        compareField("t6_late_valid", 64'(bus.out_valid),  64'd1);
        compareField("t6_late_A",     64'(bus.out_valueA), 64'h66);
`endif
        runCycle();
        idle(1'b0);
        runCycle();

        // Asynchronous reset in the middle of a cycle.
        applyStimulus(1'b1, 3'd1, 2'd3, opnd(1'b1, 3'd0, 32'hA), opnd(1'b1, 3'd0, 32'hB), 1'b0, '0, '0, 1'b1);
        runCycle();
        idle(1'b1);
        compareField("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        #1 rst = 1'b0;
        #1;
        compareField("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        compareField("rst_mid_count", 64'(bus.out_count), 64'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 2)), ALGO_W'($urandom_range(0, 3)),
                          opnd(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom),
                          opnd(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom),
                          1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 3) == 0));
            runCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
